// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store initiator for a word-wide synchronous data memory.
//            Byte/half stores are done as read-modify-write because the memory
//            has no byte enables. Loads are sign/zero extended. Misaligned,
//            invalid and timed-out accesses return an error response.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int RAM_WIDTH     = 32,  // only 32 is supported
  parameter int RAM_ADDR_BITS = 10,
  parameter int TIMEOUT       = 15   // WAIT cycles without ack before abort, >= 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // pipeline request / response
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  // memory port
  output logic                     mem_wr_en,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_data_out,
  input  logic [RAM_WIDTH-1:0]     mem_data_in,
  input  logic                     mem_rd_ack
);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [1:0] c_SZ_BAD  = 2'b11;

  // Counter must be able to hold TIMEOUT itself.
  localparam int              CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;

  // Request fields captured at accept time.
  logic                     we_q;
  logic [1:0]               size_q;
  logic                     signed_q;
  logic [1:0]               lane_q;
  logic [15:0]              wdata_q;    // sub-word stores need only the low half

  // Registered outputs.
  logic                     resp_valid_q;
  logic                     resp_err_q;
  logic [31:0]              resp_rdata_q;
  logic                     mem_wr_en_q;
  logic [RAM_ADDR_BITS-1:0] mem_addr_q;
  logic [RAM_WIDTH-1:0]     mem_data_out_q;

  logic                     w_req_err;
  logic [RAM_ADDR_BITS-1:0] w_word_addr;
  logic [7:0]               w_byte_sel;
  logic [15:0]              w_half_sel;
  logic [31:0]              w_load_fmt;
  logic [RAM_WIDTH-1:0]     w_merge;
  logic                     w_unused_addr;

  assign w_word_addr   = req_addr[RAM_ADDR_BITS+1:2];
  assign w_unused_addr = ^req_addr[31:RAM_ADDR_BITS+2];

  // Alignment / encoding check on the incoming request.
  assign w_req_err = (req_size == c_SZ_BAD)
                   | ((req_size == c_SZ_HALF) & req_addr[0])
                   | ((req_size == c_SZ_WORD) & (req_addr[1:0] != 2'b00));

  // Lane extraction, load extension and store merge on the returned word.
  always_comb begin
    w_byte_sel = mem_data_in[7:0];
    case (lane_q)
      2'd1:    w_byte_sel = mem_data_in[15:8];
      2'd2:    w_byte_sel = mem_data_in[23:16];
      2'd3:    w_byte_sel = mem_data_in[31:24];
      default: w_byte_sel = mem_data_in[7:0];
    endcase
    w_half_sel = lane_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];

    case (size_q)
      c_SZ_BYTE: w_load_fmt = {{24{signed_q & w_byte_sel[7]}}, w_byte_sel};
      c_SZ_HALF: w_load_fmt = {{16{signed_q & w_half_sel[15]}}, w_half_sel};
      default:   w_load_fmt = mem_data_in;
    endcase

    w_merge = mem_data_in;
    if (size_q == c_SZ_BYTE) begin
      case (lane_q)
        2'd1:    w_merge[15:8]  = wdata_q[7:0];
        2'd2:    w_merge[23:16] = wdata_q[7:0];
        2'd3:    w_merge[31:24] = wdata_q[7:0];
        default: w_merge[7:0]   = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      w_merge[31:16] = wdata_q;
    end else begin
      w_merge[15:0] = wdata_q;
    end
  end

  // Access sequencer: IDLE -> [RD -> WAIT ->] [WR ->] IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      lane_q         <= 2'b00;
      wdata_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      mem_wr_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;

      case (state_q)
        S_IDLE: begin
          mem_wr_en_q <= 1'b0;
          if (req_valid) begin
            if (w_req_err) begin
              // Rejected without touching the memory port.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              we_q       <= req_we;
              size_q     <= req_size;
              signed_q   <= req_signed;
              lane_q     <= req_addr[1:0];
              wdata_q    <= req_wdata[15:0];
              mem_addr_q <= w_word_addr;
              if (req_we && (req_size == c_SZ_WORD)) begin
                // Full-word store needs no read.
                mem_data_out_q <= req_wdata;
                mem_wr_en_q    <= 1'b1;
                state_q        <= S_WR;
              end else begin
                state_q <= S_RD;
              end
            end
          end
        end

        S_RD: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (mem_rd_ack) begin
            if (we_q) begin
              mem_data_out_q <= w_merge;
              mem_wr_en_q    <= 1'b1;
              state_q        <= S_WR;
            end else begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= w_load_fmt;
              state_q      <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
            if (cnt_q == c_CNT_LAST) begin
              // Memory never answered: abort, no write.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end

        S_WR: begin
          mem_wr_en_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit with a registered-read
//            memory model. Driver pushes expected responses; a monitor pops
//            and compares whenever resp_valid is seen.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_rd_ack;

  mem_access_unit #(
    .RAM_WIDTH     (32),
    .RAM_ADDR_BITS (10),
    .TIMEOUT       (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_rd_ack   (mem_rd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read, acks every non-write cycle.
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic        ack_en;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_data_out;
    mem_data_in <= mem[mem_addr];
    mem_rd_ack  <= ack_en & ~mem_wr_en;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_count = 0;
  always @(negedge clk) if (mem_wr_en) wr_count = wr_count + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          tag;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every response must match the oldest expectation, including timing.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("resp_rdata#%0d", e.tag), resp_rdata, e.rdata);
        chk($sformatf("resp_err#%0d", e.tag), {31'd0, resp_err}, {31'd0, e.err});
        chk($sformatf("resp_cycle#%0d", e.tag), cyc, e.cyc);
        chk($sformatf("ready_at_resp#%0d", e.tag), {31'd0, req_ready}, 32'd1);
      end
    end
  end

  // Present one request, return #1 after the accepting edge (i.e. in cycle 1).
  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_err, input logic [31:0] e_rdata,
                       input int lat, input int tag, input bit push);
    int g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) chk($sformatf("ready_wait#%0d", tag), 32'd0, 32'd1);
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e.err   = e_err;
      e.rdata = e_rdata;
      e.cyc   = cyc + lat - 1;
      e.tag   = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int tag);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !req_ready) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("drain#%0d", tag), exp_q.size(), 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int wr0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; ack_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_data_out", mem_data_out, 32'd0);
    rst = 1'b0;

    // Word store: single write in cycle 1, response in cycle 2
    wr0 = wr_count;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1, 1'b1);
    chk("sw_wr_en_c1", {31'd0, mem_wr_en}, 32'd1);
    chk("sw_addr_c1", {22'd0, mem_addr}, 32'd4);
    chk("sw_data_c1", mem_data_out, 32'hDEADBEEF);
    wait_idle(1);
    chk("sw_write_count", wr_count - wr0, 32'd1);

    // Word load
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 2, 1'b1);
    chk("lw_addr_c1", {22'd0, mem_addr}, 32'd4);
    chk("lw_wr_en_c1", {31'd0, mem_wr_en}, 32'd0);
    wait_idle(2);

    // Byte store into lane 3 (upper wdata bits must be ignored)
    wr0 = wr_count;
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456AA, 1'b0, 32'h0, 4, 3, 1'b1);
    chk("sb_wr_en_c1", {31'd0, mem_wr_en}, 32'd0);
    next_cycle();
    chk("sb_wr_en_c2", {31'd0, mem_wr_en}, 32'd0);
    next_cycle();
    chk("sb_wr_en_c3", {31'd0, mem_wr_en}, 32'd1);
    chk("sb_data_c3", mem_data_out, 32'hAAADBEEF);
    chk("sb_addr_c3", {22'd0, mem_addr}, 32'd4);
    wait_idle(3);
    chk("sb_write_count", wr_count - wr0, 32'd1);

    // Byte / half loads with both extensions, back to back
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFFFFAA, 3, 4, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h000000AA, 3, 5, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFAAAD, 3, 6, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000AAAD, 3, 7, 1'b1);
    wait_idle(7);

    // Error requests: no memory activity, mem_addr keeps last value (4)
    wr0 = wr_count;
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1, 8, 1'b1);
    chk("lhu_mis_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("lhu_mis_addr", {22'd0, mem_addr}, 32'd4);
    issue(1'b1, 2'b11, 1'b0, 32'h24, 32'h5, 1'b1, 32'h0, 1, 9, 1'b1);
    chk("size11_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("size11_addr", {22'd0, mem_addr}, 32'd4);
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h5, 1'b1, 32'h0, 1, 10, 1'b1);
    wait_idle(10);
    chk("err_write_count", wr_count - wr0, 32'd0);

    // Half store lane 0, then reads of the merged word
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, 1'b0, 32'h0, 4, 11, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h00000012, 3, 12, 1'b1);
    issue(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, 32'hAAAD1234, 3, 13, 1'b1);
    // Byte store lane 1 into a fresh word
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, 1'b0, 32'h0, 4, 14, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'hFFFFFF80, 3, 15, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00008000, 3, 16, 1'b1);
    wait_idle(16);

    // Timeout: memory never acks; 15 WAIT cycles (2..16), error in cycle 17
    ack_en = 1'b0;
    wr0 = wr_count;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 17, 17, 1'b1);
    wait_idle(17);
    chk("timeout_write_count", wr_count - wr0, 32'd0);
    ack_en = 1'b1;

    // Reset during WAIT of a half store: write dropped
    wr0 = wr_count;
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00005555, 1'b0, 32'h0, 4, 18, 1'b0);
    next_cycle();                 // cycle 2: WAIT
    rst = 1'b1;
    next_cycle();                 // cycle 3: reset applied
    chk("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("midrst_addr", {22'd0, mem_addr}, 32'd0);
    chk("midrst_data_out", mem_data_out, 32'd0);
    rst = 1'b0;
    next_cycle();
    chk("midrst_ready_after", {31'd0, req_ready}, 32'd1);
    chk("midrst_write_count", wr_count - wr0, 32'd0);
    chk("midrst_mem_word", mem[4], 32'hAAAD1234);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hAAAD1234, 3, 19, 1'b1);
    wait_idle(19);

    // Request coincident with reset is not accepted
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_size = 2'b11; req_addr = 32'h0;
    next_cycle();
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
